// File: rtl/wb_regfile.sv
// wb_regfile: RV32I writeback mux, 32-entry register file with two combinational read
// ports and a committed-write counter. Define REGFILE_BYPASS_EN for write-through reads.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    regwen_WB,
    input  logic [1:0]              WBsel_WB,
    input  logic [XLEN-1:0]         alu_WB,
    input  logic [XLEN-1:0]         mem_WB,
    input  logic [XLEN-1:0]         pc_WB,
    input  logic [$clog2(NREG)-1:0] dest_WB,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic [XLEN-1:0]         wb_data,
    output logic                    wb_commit,
    output logic [CNT_W-1:0]        wb_count
);

    localparam int AW = $clog2(NREG);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    logic [XLEN-1:0] regs [NREG];

    always_comb begin
        wb_data = '0;
        case (WBsel_WB)
            SEL_ALU: wb_data = alu_WB;
            SEL_MEM: wb_data = mem_WB;
            SEL_PC4: wb_data = pc_WB + XLEN'(4);
            default: wb_data = '0;
        endcase
    end

    // The reserved select is a silent no-op: no write, no count.
    assign wb_commit = regwen_WB && (dest_WB != '0) && (WBsel_WB != SEL_RSV);

    // Entry 0 is never written because wb_commit excludes dest 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_commit) begin
            regs[dest_WB] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count <= '0;
        end else if (wb_commit) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

    // Reset gating keeps reads at zero even when the bypass path would fire.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] value;
        value = '0;
        if (rst && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wb_commit && (addr == dest_WB)) begin
                value = wb_data;
            end else begin
                value = stored;
            end
`else
            value = stored;
`endif
        end
        return value;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr, regs[rs1_addr]);
        rs2_data = read_port(rs2_addr, regs[rs2_addr]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; directed test-plan sequences followed by
// random traffic, checked against an array-based reference model (counter built 4 bits wide).
module tb_wb_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             regwen_WB = 1'b0;
    logic [1:0]       WBsel_WB = 2'b00;
    logic [XLEN-1:0]  alu_WB = '0;
    logic [XLEN-1:0]  mem_WB = '0;
    logic [XLEN-1:0]  pc_WB = '0;
    logic [4:0]       dest_WB = '0;
    logic [4:0]       rs1_addr = '0;
    logic [4:0]       rs2_addr = '0;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  wb_data;
    logic             wb_commit;
    logic [CNT_W-1:0] wb_count;

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .regwen_WB(regwen_WB), .WBsel_WB(WBsel_WB),
        .alu_WB(alu_WB), .mem_WB(mem_WB), .pc_WB(pc_WB), .dest_WB(dest_WB),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .wb_data(wb_data), .wb_commit(wb_commit),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] wbd;
        logic            commit;
        int              cnt;
    } exp_t;

    exp_t            scoreboard [$];
    logic [XLEN-1:0] model_regs [NREG];
    int              model_cnt = 0;
    int              errors = 0;
    int              checks = 0;

    // Reference model: the architectural meaning of each select code.
    function automatic logic [XLEN-1:0] modelWb(input logic [1:0] sel, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] m, input logic [XLEN-1:0] p);
        longint unsigned sum;
        if (sel == 2'd0) return a;
        if (sel == 2'd1) return m;
        if (sel == 2'd2) begin
            sum = longint'(p) + 64'd4;
            return sum[XLEN-1:0];
        end
        return '0;
    endfunction

    function automatic logic modelCommit(input logic ren, input logic [1:0] sel, input logic [4:0] d);
        return ren && (d != 5'd0) && (sel != 2'd3);
    endfunction

    function automatic logic [XLEN-1:0] modelRead(input logic [4:0] addr);
        if (!rst || addr == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (modelCommit(regwen_WB, WBsel_WB, dest_WB) && addr == dest_WB)
            return modelWb(WBsel_WB, alu_WB, mem_WB, pc_WB);
`endif
        return model_regs[addr];
    endfunction

    // One cycle: let the model see the edge, then drive new inputs and queue the expectation.
    task automatic applyStimulus(input logic rst_v, input logic ren, input logic [1:0] sel,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] m,
                                 input logic [XLEN-1:0] p, input logic [4:0] d,
                                 input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge clk);
        if (rst && modelCommit(regwen_WB, WBsel_WB, dest_WB)) begin
            model_regs[dest_WB] = modelWb(WBsel_WB, alu_WB, mem_WB, pc_WB);
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end
        #1;
        rst = rst_v; regwen_WB = ren; WBsel_WB = sel; alu_WB = a; mem_WB = m; pc_WB = p;
        dest_WB = d; rs1_addr = r1; rs2_addr = r2;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) model_regs[i] = '0;
            model_cnt = 0;
        end
        e.rs1    = modelRead(r1);
        e.rs2    = modelRead(r2);
        e.wbd    = modelWb(sel, a, m, p);
        e.commit = modelCommit(ren, sel, d);
        e.cnt    = model_cnt;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 5;
        if (rs1_data !== e.rs1) begin
            errors++;
            $display("[TB] FAIL rs1_data t=%0t got=%h exp=%h", $time, rs1_data, e.rs1);
        end
        if (rs2_data !== e.rs2) begin
            errors++;
            $display("[TB] FAIL rs2_data t=%0t got=%h exp=%h", $time, rs2_data, e.rs2);
        end
        if (wb_data !== e.wbd) begin
            errors++;
            $display("[TB] FAIL wb_data t=%0t got=%h exp=%h", $time, wb_data, e.wbd);
        end
        if (wb_commit !== e.commit) begin
            errors++;
            $display("[TB] FAIL wb_commit t=%0t got=%b exp=%b", $time, wb_commit, e.commit);
        end
        if (wb_count !== CNT_W'(e.cnt)) begin
            errors++;
            $display("[TB] FAIL wb_count t=%0t got=%0d exp=%0d", $time, wb_count, e.cnt);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [4:0]      d;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic [XLEN-1:0] v;
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;

        repeat (3) applyStimulus(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Write x5, read it back, then assert reset mid-cycle while still reading x5.
        applyStimulus(1, 1, 2'd0, 32'h12345678, 0, 0, 5, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 5, 5);
        applyStimulus(0, 1, 2'd0, 32'hCAFEF00D, 0, 0, 6, 5, 6);
        applyStimulus(0, 1, 2'd0, 32'hCAFEF00D, 0, 0, 6, 5, 6);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 5, 6);

        // Source select walk: x1/x2/x3 from ALU, memory, PC+4.
        applyStimulus(1, 1, 2'd0, 32'h11, 32'h22, 32'h100, 1, 0, 0);
        applyStimulus(1, 1, 2'd1, 32'h11, 32'h22, 32'h100, 2, 1, 0);
        applyStimulus(1, 1, 2'd2, 32'h11, 32'h22, 32'h100, 3, 1, 2);
        applyStimulus(1, 1, 2'd3, 32'h11, 32'h22, 32'h100, 4, 3, 4);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 4, 3);

        // x0 write attempt and PC wrap.
        applyStimulus(1, 1, 2'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2'd2, 0, 0, 32'hFFFFFFFC, 7, 0, 0);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 7, 0);

        // Same-cycle hazard on x9 from both ports.
        applyStimulus(1, 1, 2'd0, 32'hA5A5A5A5, 0, 0, 9, 9, 9);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 9, 9);

        // Drive the counter to all-ones, then one more commit wraps it.
        for (int i = 0; i < 20 && model_cnt != (1 << CNT_W) - 1; i++)
            applyStimulus(1, 1, 2'd1, 0, 32'h100 + i, 0, 10, 10, 9);
        applyStimulus(1, 1, 2'd0, 32'h77, 0, 0, 11, 10, 11);
        applyStimulus(1, 0, 2'd0, 32'h55, 0, 0, 12, 11, 12);

        // regwen low with valid data.
        applyStimulus(1, 0, 2'd0, 32'h99999999, 0, 0, 12, 12, 11);
        applyStimulus(1, 0, 2'd0, 0, 0, 0, 0, 12, 11);

        for (int n = 0; n < 400; n++) begin
            d  = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            v  = $urandom;
            applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), v, $urandom,
                          ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom, d, r1, r2);
        end

        @(negedge clk);
        #1;
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d exp=0", scoreboard.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
